// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the set-associative cache.
package cache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOOKUP = 3'd1;
  localparam state_t WBACK  = 3'd2;
  localparam state_t REFILL = 3'd3;
  localparam state_t DONE   = 3'd4;

  function automatic int log2(input int v);
    int r;
    int one;
    r   = 0;
    one = 1;
    for (int i = 0; i < 31; i++) begin
      r = ((one << i) < v) ? i + 1 : r;
    end
    return r;
  endfunction

  function automatic int sets_f(input int cache_size, input int block_size, input int ways);
    int one;
    one = 1;
    return (one << cache_size) / (block_size * ways);
  endfunction

  function automatic int off_w(input int block_size);
    return log2(block_size);
  endfunction

  function automatic int idx_w(input int cache_size, input int block_size, input int ways);
    return log2(sets_f(cache_size, block_size, ways));
  endfunction

  function automatic int tag_w(input int cache_size, input int block_size, input int ways);
    return 32 - off_w(block_size) - idx_w(cache_size, block_size, ways);
  endfunction

  // Way pointers keep at least one bit so direct-mapped builds still have legal vectors.
  function automatic int way_w(input int ways);
    return (ways > 1) ? log2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim choice on a miss: lowest-index invalid way, else the set's round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter  int WAYS = 2,
  localparam int WW   = way_w(WAYS)
)(
  input  logic [WAYS-1:0] valid_i,
  input  logic [WW-1:0]   rr_i,
  output logic [WW-1:0]   victim_o,
  output logic            victim_valid_o
);

  logic [WW-1:0] pick_s;
  logic          found_s;

  always_comb begin
    pick_s  = rr_i;
    found_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      pick_s  = (!found_s && !valid_i[w]) ? WW'(w) : pick_s;
      found_s = found_s | ~valid_i[w];
    end
    victim_o       = (WAYS == 1) ? '0 : pick_s;
    victim_valid_o = valid_i[victim_o];
  end

endmodule

// File: rtl/cache_set_assoc.sv
// Write-back, write-allocate set-associative cache serving one request at a time.
// Defining CACHE_STATS_EN adds the hit_cnt / miss_cnt counter outputs.
module cache_set_assoc
  import cache_pkg::*;
#(
  parameter int CACHE_SIZE = 12,
  parameter int BLOCK_SIZE = 4,
  parameter int WAYS       = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    wr,
  input  logic [31:0]             addr,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    ready,
  output logic                    hit,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [31:0]             mem_addr,
  output logic [BLOCK_SIZE*8-1:0] mem_wdata,
  input  logic [BLOCK_SIZE*8-1:0] mem_rdata,
  input  logic                    mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int SETS  = sets_f(CACHE_SIZE, BLOCK_SIZE, WAYS);
  localparam int OFF_W = off_w(BLOCK_SIZE);
  localparam int IDX_W = idx_w(CACHE_SIZE, BLOCK_SIZE, WAYS);
  localparam int TAG_W = tag_w(CACHE_SIZE, BLOCK_SIZE, WAYS);
  localparam int WW    = way_w(WAYS);
  localparam int DW    = BLOCK_SIZE * 8;

  state_t          state_q, state_d;
  logic            wr_q;
  logic [31:0]     addr_q;
  logic [DW-1:0]   din_q;
  logic [WW-1:0]   way_q, way_d;
  logic            evict_q, evict_d;
  logic            ready_q, ready_d, hit_q, hit_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WW-1:0]    rr_q    [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [DW-1:0]    data_q  [WAYS][SETS];

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [WAYS-1:0]  match_s;
  logic             hit_s;
  logic [WW-1:0]    hit_way_s, victim_s;
  logic             victim_valid_s, fill_s, wr_hit_s;
  logic [WW-1:0]    rr_next_s;
  logic [31:0]      fill_addr_s, vic_addr_s;

  assign idx_s       = addr_q[OFF_W +: IDX_W];
  assign tag_s       = addr_q[31 -: TAG_W];
  assign fill_addr_s = 32'({tag_s, idx_s}) << OFF_W;
  assign vic_addr_s  = 32'({tag_q[victim_s][idx_s], idx_s}) << OFF_W;
  assign fill_s      = (state_q == REFILL) && mem_ack;
  assign wr_hit_s    = (state_q == LOOKUP) && hit_s && wr_q;
  assign rr_next_s   = (WAYS > 1) ? rr_q[idx_s] + 1'b1 : '0;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_q[idx_s][w] && (tag_q[w][idx_s] == tag_s);
      hit_way_s  = match_s[w] ? WW'(w) : hit_way_s;
    end
    hit_s = |match_s;
  end

  cache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid_i        (valid_q[idx_s]),
    .rr_i           (rr_q[idx_s]),
    .victim_o       (victim_s),
    .victim_valid_o (victim_valid_s)
  );

  // Next-state and next-output logic; memory fields are set once on entry and held until mem_ack
  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    evict_d     = evict_q;
    ready_d     = 1'b0;
    hit_d       = hit_q;
    dout_d      = dout_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: state_d = req ? LOOKUP : IDLE;
      LOOKUP: begin
        if (hit_s) begin
          state_d = DONE;
          ready_d = 1'b1;
          hit_d   = 1'b1;
          way_d   = hit_way_s;
          dout_d  = wr_q ? din_q : data_q[hit_way_s][idx_s];
        end else begin
          way_d     = victim_s;
          evict_d   = victim_valid_s;
          mem_req_d = 1'b1;
          if (victim_valid_s && dirty_q[idx_s][victim_s]) begin
            state_d     = WBACK;
            mem_wr_d    = 1'b1;
            mem_addr_d  = vic_addr_s;
            mem_wdata_d = data_q[victim_s][idx_s];
          end else begin
            state_d    = REFILL;
            mem_wr_d   = 1'b0;
            mem_addr_d = fill_addr_s;
          end
        end
      end
      WBACK: begin
        if (mem_ack) begin
          state_d    = REFILL;
          mem_wr_d   = 1'b0;
          mem_addr_d = fill_addr_s;
        end else begin
          state_d = WBACK;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          state_d   = DONE;
          ready_d   = 1'b1;
          hit_d     = 1'b0;
          dout_d    = wr_q ? din_q : mem_rdata;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
        end else begin
          state_d = REFILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, request capture and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      din_q       <= '0;
      way_q       <= '0;
      evict_q     <= 1'b0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      dout_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      evict_q     <= evict_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      dout_q      <= dout_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == IDLE && req) begin
        wr_q   <= wr;
        addr_q <= addr;
        din_q  <= din;
      end
    end
  end

  // Line state: the round-robin pointer only moves when a valid line is displaced
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (wr_hit_s) begin
      dirty_q[idx_s][hit_way_s] <= 1'b1;
    end else if (fill_s) begin
      valid_q[idx_s][way_q] <= 1'b1;
      dirty_q[idx_s][way_q] <= wr_q;
      if (evict_q) begin
        rr_q[idx_s] <= rr_next_s;
      end
    end
  end

  // Tag and data storage carries no reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (!rst && wr_hit_s) begin
      data_q[hit_way_s][idx_s] <= din_q;
    end else if (!rst && fill_s) begin
      tag_q[way_q][idx_s]  <= tag_s;
      data_q[way_q][idx_s] <= wr_q ? din_q : mem_rdata;
    end
  end

  assign dout      = dout_q;
  assign ready     = ready_q;
  assign hit       = hit_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Counters advance in step with the ready pulse they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (ready_d && hit_d) begin
      hit_cnt_q <= hit_cnt_q + 32'd1;
    end else if (ready_d) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed scoreboard bench: a 2-way default cache plus a direct-mapped instance.
`timescale 1ns/1ps
module tb_cache_set_assoc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, wr, ready, hit, mem_req, mem_wr, mem_ack;
  logic [31:0] addr, din, dout, mem_addr, mem_wdata, mem_rdata;
  logic        req1, wr1, ready1, hit1, mem_req1, mem_wr1, mem_ack1;
  logic [31:0] addr1, din1, dout1, mem_addr1, mem_wdata1, mem_rdata1;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, hit_cnt1, miss_cnt1;
`endif

  cache_set_assoc dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .din(din), .dout(dout),
    .ready(ready), .hit(hit), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  cache_set_assoc #(.CACHE_SIZE(12), .BLOCK_SIZE(4), .WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .addr(addr1), .din(din1), .dout(dout1),
    .ready(ready1), .hit(hit1), .mem_req(mem_req1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ack(mem_ack1)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1)
`endif
  );

  typedef struct { logic hit; logic [31:0] dout; string tag; } exp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } mop_t;

  exp_t        exp_q[$];
  mop_t        mop_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          mem_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat(a);
  endfunction

  task automatic push_mop(input logic w, input logic [31:0] a, input logic [31:0] d);
    mop_t m;
    m.wr = w; m.addr = a; m.wdata = d;
    mop_q.push_back(m);
  endtask

  // Result scoreboard: every ready pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {31'd0, ready}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_hit"}, {31'd0, hit}, {31'd0, e.hit});
          check({e.tag, "_dout"}, dout, e.dout);
        end
      end
    end
  end

  // Memory responder for the 2-way instance.
  initial begin
    mop_t        m;
    logic [31:0] a0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst === 1'b0) begin
        mem_cnt++;
        a0 = mem_addr;
        if (mop_q.size() == 0) begin
          check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
        end else begin
          m = mop_q.pop_front();
          check("mem_wr", {31'd0, mem_wr}, {31'd0, m.wr});
          check("mem_addr", mem_addr, m.addr);
          if (m.wr) check("mem_wdata", mem_wdata, m.wdata);
        end
        @(negedge clk);
        if (!rst) check("mem_hold", mem_addr, a0);
        @(posedge clk); #1;
        if (mem_wr) mem_model[mem_addr] = mem_wdata;
        mem_ack   = 1'b1;
        mem_rdata = rd_model(mem_addr);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
      end
    end
  end

  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic eh, input logic [31:0] ed, input int nmem);
    exp_t e;
    int   cyc;
    int   m0;
    e.hit = eh; e.dout = ed; e.tag = tag;
    exp_q.push_back(e);
    m0 = mem_cnt;
    @(posedge clk); #1;
    req = 1'b1; wr = w; addr = a; din = d;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (ready !== 1'b1 && cyc < 200);
    req = 1'b0; wr = 1'b0;
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    if (eh) check({tag, "_lat"}, 32'(cyc), 32'd2);
    @(negedge clk);
    check({tag, "_nmem"}, 32'(mem_cnt - m0), 32'(nmem));
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic access1(input string tag, input logic [31:0] a);
    int cyc;
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b0; addr1 = a;
    cyc = 0;
    while (mem_req1 !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_mreq"}, {31'd0, mem_req1}, 32'd1);
    check({tag, "_maddr"}, mem_addr1, a);
    mem_ack1 = 1'b1; mem_rdata1 = pat(a);
    @(posedge clk); #1;
    mem_ack1 = 1'b0; req1 = 1'b0;
    check({tag, "_ready"}, {31'd0, ready1}, 32'd1);
    check({tag, "_hit"}, {31'd0, hit1}, 32'd0);
    check({tag, "_dout"}, dout1, pat(a));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 32'd0; din = 32'd0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; din1 = 32'd0; mem_ack1 = 1'b0; mem_rdata1 = 32'd0;
    mem_model[32'h0000_1000] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_mem_req", {30'd0, mem_req, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_dout", dout, 32'd0);

    // Direct-mapped: two addresses sharing set 0 keep evicting each other.
    access1("dm0_a", 32'h0000_0000);
    access1("dm1_a", 32'h0000_1000);
    access1("dm0_b", 32'h0000_0000);
    access1("dm1_b", 32'h0000_1000);

    push_mop(1'b0, 32'h0000_1000, 32'd0);
    access("rd_miss", 1'b0, 32'h0000_1000, 32'd0, 1'b0, 32'hDEAD_BEEF, 1);
    access("rd_hit", 1'b0, 32'h0000_1003, 32'd0, 1'b1, 32'hDEAD_BEEF, 0);
    repeat (3) @(posedge clk);
    #1 check("dout_hold", dout, 32'hDEAD_BEEF);
    access("wr_hit", 1'b1, 32'h0000_1000, 32'h1111_1111, 1'b1, 32'h1111_1111, 0);
    push_mop(1'b0, 32'h0000_2000, 32'd0);
    access("fill_way1", 1'b0, 32'h0000_2000, 32'd0, 1'b0, pat(32'h0000_2000), 1);
    push_mop(1'b1, 32'h0000_1000, 32'h1111_1111);
    push_mop(1'b0, 32'h0000_3000, 32'd0);
    access("evict_dirty", 1'b0, 32'h0000_3000, 32'd0, 1'b0, pat(32'h0000_3000), 2);
    push_mop(1'b0, 32'h0000_1000, 32'd0);
    access("refetch_wb", 1'b0, 32'h0000_1000, 32'd0, 1'b0, 32'h1111_1111, 1);
    push_mop(1'b0, 32'h0000_4000, 32'd0);
    access("wr_miss", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1);
    access("rd_wr_miss", 1'b0, 32'h0000_4000, 32'd0, 1'b1, 32'hCAFE_F00D, 0);
    push_mop(1'b0, 32'h0000_5000, 32'd0);
    access("rr_way1", 1'b0, 32'h0000_5000, 32'd0, 1'b0, pat(32'h0000_5000), 1);
    push_mop(1'b1, 32'h0000_4000, 32'hCAFE_F00D);
    push_mop(1'b0, 32'h0000_6000, 32'd0);
    access("rr_way0", 1'b0, 32'h0000_6000, 32'd0, 1'b0, pat(32'h0000_6000), 2);
    access("rd_hit2", 1'b0, 32'h0000_5000, 32'd0, 1'b1, pat(32'h0000_5000), 0);
`ifdef CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'd4);
    check("miss_cnt", miss_cnt, 32'd7);
    check("hit_cnt_dm", hit_cnt1, 32'd0);
    check("miss_cnt_dm", miss_cnt1, 32'd4);
`endif

    // Reset while a refill is outstanding: no install, no ready.
    push_mop(1'b0, 32'h0000_1004, 32'd0);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h0000_1004;
    cyc = 0;
    while (mem_req !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_mreq", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_mem", {30'd0, mem_req, mem_wr}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_dout", dout, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    push_mop(1'b0, 32'h0000_1004, 32'd0);
    access("abort_remiss", 1'b0, 32'h0000_1004, 32'd0, 1'b0, pat(32'h0000_1004), 1);
    push_mop(1'b0, 32'h0000_6000, 32'd0);
    access("rst_cleared", 1'b0, 32'h0000_6000, 32'd0, 1'b0, pat(32'h0000_6000), 1);

    repeat (4) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("mop_q_empty", 32'(mop_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
